// File: rtl/div_seq.sv
// Sequential RV32M divider: one restoring step per cycle, W steps per op.
// Handles DIV/DIVU/REM/REMU, divide-by-zero and signed-overflow shortcuts.
module div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] src1_value,
  input  logic [DATA_WIDTH-1:0] src2_value,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [W-1:0]  dvd;      // dividend magnitude, shifted out MSB-first; quotient shifts in at LSB
  logic [W-1:0]  dsr;
  logic [W-1:0]  rem;
  logic          op_rem, q_neg, r_neg;

  logic          accept, is_signed, div_zero, overflow, special, last_step;
  logic [W-1:0]  a_abs, b_abs;
  logic [W:0]    rem_shift;
  logic          qbit;
  logic [W-1:0]  rem_next, q_final;

  assign accept    = (state == IDLE) && start && funct3[2];
  assign is_signed = ~funct3[0];
  assign div_zero  = (src2_value == '0);
  assign overflow  = is_signed && (src1_value == {1'b1, {(W-1){1'b0}}}) && (src2_value == '1);
  assign special   = div_zero || overflow;
  assign a_abs     = (is_signed && src1_value[W-1]) ? -src1_value : src1_value;
  assign b_abs     = (is_signed && src2_value[W-1]) ? -src2_value : src2_value;
  assign last_step = (count == LAST);

  assign rem_shift = {rem, dvd[W-1]};
  assign qbit      = (rem_shift >= {1'b0, dsr});
  // A successful subtract leaves a value below dsr, so W bits suffice.
  assign rem_next  = qbit ? (rem_shift[W-1:0] - dsr) : rem_shift[W-1:0];
  assign q_final   = {dvd[W-2:0], qbit};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = special ? DONE : RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN) || (state == DONE);
    done  = (state == DONE);
    stall = !reset && (accept || (state == RUN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      count  <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      op_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_rem <= funct3[1];
          q_neg  <= is_signed && (src1_value[W-1] ^ src2_value[W-1]);
          r_neg  <= is_signed && src1_value[W-1];
          dvd    <= a_abs;
          dsr    <= b_abs;
          rem    <= '0;
          count  <= '0;
          if (div_zero)      result <= funct3[1] ? src1_value : '1;
          else if (overflow) result <= funct3[1] ? '0 : src1_value;
        end
        RUN: begin
          rem   <= rem_next;
          dvd   <= q_final;
          count <= count + 1'b1;
          if (last_step)
            result <= op_rem ? (r_neg ? -rem_next : rem_next)
                             : (q_neg ? -q_final  : q_final);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table of ops plus reset/ignored-start sequences.
module tb_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, busy, stall, done;
  logic [2:0]   funct3;
  logic [W-1:0] src1_value, src2_value, result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .src1_value(src1_value), .src2_value(src2_value),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
  } vec_t;

  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge while the DUT is IDLE; returns one cycle after DONE.
  task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, output logic [W-1:0] res, output int lat,
                        output int stalls);
    start = 1'b1; funct3 = f3; src1_value = a; src2_value = b;
    lat = 0; stalls = 0;
    #1;
    if (stall) stalls++;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (stall) stalls++;
      if (lat == inj) begin
        start = 1'b1; funct3 = REMU; src1_value = 50; src2_value = 3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("done_seen", W'(done), W'(1));
    check("stall_in_done", W'(stall), W'(0));
    res = result;
    @(posedge clk); #1;
    check("done_pulse_width", W'(done), W'(0));
    check("busy_after_done", W'(busy), W'(0));
  endtask

  vec_t         vecs [16];
  logic [W-1:0] res;
  int           lat, stalls;
  logic         seen_done;

  initial begin
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
    vecs[3]  = '{REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
    vecs[4]  = '{REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33};
    vecs[5]  = '{DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1};
    vecs[6]  = '{REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[7]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
    vecs[8]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
    vecs[9]  = '{DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
    vecs[10] = '{DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33};
    vecs[11] = '{REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   33};
    vecs[12] = '{REMU, 32'd7,          32'd100,        32'd7,          33};
    vecs[13] = '{DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33};
    vecs[14] = '{DIV,  32'h80000000,   32'd1,          32'h80000000,   33};
    vecs[15] = '{DIVU, 32'd0,          32'd0,          32'hFFFFFFFF,   1};

    reset = 1'b1; start = 1'b0; funct3 = 3'b000; src1_value = '0; src2_value = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; funct3 = DIVU; src1_value = 32'd100; src2_value = 32'd7;
    #1;
    check("reset_stall", W'(stall), W'(0));
    @(posedge clk); #1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, '0);
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, -1, res, lat, stalls);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat));
      check($sformatf("vec%0d_stalls", i), W'(stalls), W'(vecs[i].lat));
    end

    // Reset on the 10th RUN cycle discards the op.
    start = 1'b1; funct3 = DIVU; src1_value = 32'd100; src2_value = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrun_busy", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    check("midrun_reset_stall", W'(stall), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun_busy_after", W'(busy), W'(0));
    check("midrun_result", result, '0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("midrun_no_done", W'(seen_done), W'(0));
    run_op(DIVU, 32'd9, 32'd3, -1, res, lat, stalls);
    check("post_reset_result", res, 32'd3);

    // start during RUN must not disturb the op in flight.
    run_op(DIVU, 32'd1000, 32'd10, 5, res, lat, stalls);
    check("inj_result", res, 32'd100);
    check("inj_latency", W'(lat), W'(33));

    // Non-divide funct3 in IDLE is ignored.
    start = 1'b1; funct3 = 3'b000; src1_value = 32'd77; src2_value = 32'd0;
    #1;
    check("f3_000_stall", W'(stall), W'(0));
    @(posedge clk); #1;
    start = 1'b0;
    check("f3_000_busy", W'(busy), W'(0));
    check("f3_000_result", result, 32'd100);
    @(posedge clk); #1;
    check("f3_000_done", W'(done), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
